// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// One 1-bit full-adder cell with a registered carry adds two WIDTH-bit operands
// LSB-first, one bit per clock, under a start/busy/done handshake. The final
// sum, carry-out and signed overflow stay on the result ports until the next
// completed operation.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled in IDLE or DONE only
//   clr    synchronous abort to IDLE (no done, results retained)
//   a, b   WIDTH-bit operands, captured on an accepted start
//   cin    carry-in, captured on an accepted start
//   busy   high while the serial add is running
//   done   one-cycle pulse after the result registers update
//   sum    WIDTH-bit result (modulo 2^WIDTH)
//   cout   carry out of bit WIDTH-1
//   ovf    two's-complement overflow
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sa_q, sa_d;
    logic [WIDTH-1:0]  sb_q, sb_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    // Only WIDTH-1 partial bits need storing: the final bit enters straight
    // into sum on the last cycle.
    logic [WIDTH-2:0]  res_q, res_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic              s_bit;
    logic              c_bit;
    logic              last;
    logic [WIDTH-1:0]  res_next;

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        s_bit    = sa_q[0] ^ sb_q[0] ^ carry_q;
        c_bit    = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
        last     = (cnt_q == CntW'(WIDTH - 1));
        res_next = {s_bit, res_q};

        if (clr) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StRun;
                        sa_d    = a;
                        sb_d    = b;
                        carry_d = cin;
                        cnt_d   = '0;
                        res_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StRun: begin
                    sa_d    = sa_q >> 1;
                    sb_d    = sb_q >> 1;
                    carry_d = c_bit;
                    cnt_d   = cnt_q + CntW'(1);
                    res_d   = res_next[WIDTH-1:1];
                    if (last) begin
                        sum_d   = res_next;
                        cout_d  = c_bit;
                        // Overflow: carry into the MSB differs from carry out.
                        ovf_d   = carry_q ^ c_bit;
                        state_d = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
